// File: rtl/sig_echo.sv
//=============================================================================
// Module      : sig_echo
// Description : Two-tap echo/delay block. Samples are written to a circular
//               buffer; two independently delayed taps are read back, tap A
//               may be fed back into the buffer, and a saturated mix of the
//               input and both taps is produced. Two-stage pipeline.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module sig_echo #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] mic_in,
    input  logic [AW-1:0] delay_a,
    input  logic [AW-1:0] delay_b,
    input  logic          fb_en,
    input  logic [1:0]    fb_shift,
    output logic [DW-1:0] original,
    output logic [DW-1:0] tap_a_out,
    output logic [DW-1:0] tap_b_out,
    output logic [DW-1:0] mix_out,
    output logic          out_valid
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [DW-1:0] MID      = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW-1:0] FILL_MAX = '1;

    // Signed working type with two guard bits so three-term sums never wrap.
    typedef logic signed [DW+1:0] wide_t;

    localparam wide_t S_MAX = wide_t'((1 << (DW-1)) - 1);
    localparam wide_t S_MIN = -S_MAX - wide_t'(1);

    // Offset-binary to sign-extended two's complement.
    function automatic wide_t to_wide(input logic [DW-1:0] ob);
        logic [DW-1:0] s;
        s = {~ob[DW-1], ob[DW-2:0]};
        return {{2{s[DW-1]}}, s};
    endfunction

    // Clamp to the signed sample range and return offset-binary.
    function automatic logic [DW-1:0] sat_ob(input wide_t v);
        logic [DW-1:0] r;
        if (v > S_MAX) begin
            r = '1;
        end else if (v < S_MIN) begin
            r = '0;
        end else begin
            r = {~v[DW-1], v[DW-2:0]};
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] fill_q, fill_d;

    // Stage-1 registers (captured on the accepting edge)
    logic          s1_vld_q;
    logic [DW-1:0] x_q;
    logic [AW-1:0] s1_wptr_q;
    logic          a_byp_q, b_byp_q;
    logic          a_ok_q,  b_ok_q;
    logic          fb_en_q;
    logic [1:0]    fb_shift_q;
    logic [DW-1:0] rd_a_q, rd_b_q;

    // Registered outputs
    logic [DW-1:0] original_q, tap_a_q, tap_b_q, mix_q;
    logic          out_valid_q;

    logic [DW-1:0] mem [DEPTH];

    // ---------------------------------------------------------- datapath
    logic [AW-1:0] w_raddr_a, w_raddr_b;
    logic [DW-1:0] w_tap_a, w_tap_b, w_wdata;
    logic [2:0]    w_fb_sh;
    wide_t         w_x, w_ta, w_tb, w_fb_sum, w_mix;

    assign w_raddr_a = wptr_q - delay_a;
    assign w_raddr_b = wptr_q - delay_b;

    // Pointer and fill next-state: advance only on an accepted sample.
    always_comb begin
        wptr_d = wptr_q;
        fill_d = fill_q;
        if (en) begin
            wptr_d = wptr_q + AW'(1);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + AW'(1);
            end
        end
    end

    // Stage-1 tap selection, feedback write data and output mix.
    always_comb begin
        w_tap_a  = a_byp_q ? x_q : (a_ok_q ? rd_a_q : MID);
        w_tap_b  = b_byp_q ? x_q : (b_ok_q ? rd_b_q : MID);
        w_x      = to_wide(x_q);
        w_ta     = to_wide(w_tap_a);
        w_tb     = to_wide(w_tap_b);
        w_fb_sh  = {1'b0, fb_shift_q} + 3'd1;
        w_fb_sum = w_x + (w_ta >>> w_fb_sh);
        w_wdata  = fb_en_q ? sat_ob(w_fb_sum) : x_q;
        w_mix    = w_x + (w_ta >>> 1) + (w_tb >>> 2);
    end

    // Buffer write for the stage-1 sample and synchronous tap reads for the
    // newly accepted sample; a read of the slot being written this edge
    // returns the new write data.
    always_ff @(posedge clk) begin
        if (s1_vld_q) begin
            mem[s1_wptr_q] <= w_wdata;
        end
        if (en) begin
            rd_a_q <= (s1_vld_q && (w_raddr_a == s1_wptr_q)) ? w_wdata : mem[w_raddr_a];
            rd_b_q <= (s1_vld_q && (w_raddr_b == s1_wptr_q)) ? w_wdata : mem[w_raddr_b];
        end
    end

    // Stage 0: capture the sample, its slot, its controls and tap validity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            fill_q     <= '0;
            s1_vld_q   <= 1'b0;
            x_q        <= MID;
            s1_wptr_q  <= '0;
            a_byp_q    <= 1'b0;
            b_byp_q    <= 1'b0;
            a_ok_q     <= 1'b0;
            b_ok_q     <= 1'b0;
            fb_en_q    <= 1'b0;
            fb_shift_q <= 2'd0;
        end else begin
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            s1_vld_q <= en;
            if (en) begin
                x_q        <= mic_in;
                s1_wptr_q  <= wptr_q;
                a_byp_q    <= (delay_a == '0);
                b_byp_q    <= (delay_b == '0);
                a_ok_q     <= (delay_a <= fill_q);
                b_ok_q     <= (delay_b <= fill_q);
                fb_en_q    <= fb_en;
                fb_shift_q <= fb_shift;
            end
        end
    end

    // Stage 1: register outputs; they hold until the next sample completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            original_q  <= MID;
            tap_a_q     <= MID;
            tap_b_q     <= MID;
            mix_q       <= MID;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                original_q <= x_q;
                tap_a_q    <= w_tap_a;
                tap_b_q    <= w_tap_b;
                mix_q      <= sat_ob(w_mix);
            end
        end
    end

    assign original  = original_q;
    assign tap_a_out = tap_a_q;
    assign tap_b_out = tap_b_q;
    assign mix_out   = mix_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sig_echo.sv
//=============================================================================
// Module      : tb_sig_echo
// Description : Self-checking bench for sig_echo with a sample-history model.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_sig_echo;

    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int NMAX = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [DW-1:0] mic_in   = 8'd128;
    logic [AW-1:0] delay_a  = '0;
    logic [AW-1:0] delay_b  = '0;
    logic          fb_en    = 1'b0;
    logic [1:0]    fb_shift = 2'd0;
    logic [DW-1:0] original, tap_a_out, tap_b_out, mix_out;
    logic          out_valid;

    always #5 clk = ~clk;

    sig_echo #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mic_in    (mic_in),
        .delay_a   (delay_a),
        .delay_b   (delay_b),
        .fb_en     (fb_en),
        .fb_shift  (fb_shift),
        .original  (original),
        .tap_a_out (tap_a_out),
        .tap_b_out (tap_b_out),
        .mix_out   (mix_out),
        .out_valid (out_valid)
    );

    int checks   = 0;
    int failures = 0;

    int st_x[NMAX], st_da[NMAX], st_db[NMAX], st_fbe[NMAX], st_fsh[NMAX];
    int ex_orig[NMAX], ex_a[NMAX], ex_b[NMAX], ex_mix[NMAX];
    int got_orig[NMAX], got_a[NMAX], got_b[NMAX], got_mix[NMAX];
    int got_n;
    int hist[$];   // signed values written to the buffer since reset

    function automatic int clampi(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference: tap = value written d samples ago, midscale if not yet
    // written since reset, or the input itself for d == 0.
    task automatic model_sample(input int i);
        int s, n, ta, tb, wr;
        s  = st_x[i] - 128;
        n  = hist.size();
        ta = (st_da[i] == 0) ? s : ((st_da[i] <= n) ? hist[n - st_da[i]] : 0);
        tb = (st_db[i] == 0) ? s : ((st_db[i] <= n) ? hist[n - st_db[i]] : 0);
        wr = (st_fbe[i] != 0) ? clampi(s + (ta >>> (st_fsh[i] + 1))) : s;
        hist.push_back(wr);
        ex_orig[i] = st_x[i];
        ex_a[i]    = ta + 128;
        ex_b[i]    = tb + 128;
        ex_mix[i]  = clampi(s + (ta >>> 1) + (tb >>> 2)) + 128;
    endtask

    task automatic set_sample(input int i, input int x, input int da, input int db,
                              input int fbe, input int fsh);
        st_x[i] = x; st_da[i] = da; st_db[i] = db; st_fbe[i] = fbe; st_fsh[i] = fsh;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
    endtask

    // Stream n prepared samples (optionally with random idle cycles) and
    // collect every out_valid cycle's outputs in order.
    task automatic run_samples(input int n, input int gap_pct);
        int sent;
        int budget;
        sent   = 0;
        budget = 0;
        got_n  = 0;
        while ((got_n < n) && (budget < 4 * n + 20)) begin
            @(negedge clk);
            if ((sent < n) && ($urandom_range(99) >= gap_pct)) begin
                en       = 1'b1;
                mic_in   = DW'(st_x[sent]);
                delay_a  = AW'(st_da[sent]);
                delay_b  = AW'(st_db[sent]);
                fb_en    = st_fbe[sent][0];
                fb_shift = 2'(st_fsh[sent]);
                model_sample(sent);
                sent++;
            end else begin
                en = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid && (got_n < NMAX)) begin
                got_orig[got_n] = int'(original);
                got_a[got_n]    = int'(tap_a_out);
                got_b[got_n]    = int'(tap_b_out);
                got_mix[got_n]  = int'(mix_out);
                got_n++;
            end
            budget++;
        end
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (got_n != n) begin
            failures++;
            $display("FAIL run_count: got %0d outputs, expected %0d", got_n, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 5;
        if (original  !== 8'd128) begin failures++; $display("FAIL reset_original got=%0d exp=128", original); end
        if (tap_a_out !== 8'd128) begin failures++; $display("FAIL reset_tap_a got=%0d exp=128", tap_a_out); end
        if (tap_b_out !== 8'd128) begin failures++; $display("FAIL reset_tap_b got=%0d exp=128", tap_b_out); end
        if (mix_out   !== 8'd128) begin failures++; $display("FAIL reset_mix got=%0d exp=128", mix_out); end
        if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_impulse();
        int ea, eb, em;
        do_reset();
        for (int i = 0; i < 8; i++) set_sample(i, (i == 0) ? 228 : 128, 3, 5, 0, 0);
        run_samples(8, 0);
        for (int k = 0; k < 8; k++) begin
            ea = (k == 3) ? 228 : 128;
            eb = (k == 5) ? 228 : 128;
            em = (k == 0) ? 228 : (k == 3) ? 178 : (k == 5) ? 153 : 128;
            checks += 4;
            if (got_orig[k] !== st_x[k]) begin failures++; $display("FAIL impulse_orig[%0d] got=%0d exp=%0d", k, got_orig[k], st_x[k]); end
            if (got_a[k]   !== ea) begin failures++; $display("FAIL impulse_tap_a[%0d] got=%0d exp=%0d", k, got_a[k], ea); end
            if (got_b[k]   !== eb) begin failures++; $display("FAIL impulse_tap_b[%0d] got=%0d exp=%0d", k, got_b[k], eb); end
            if (got_mix[k] !== em) begin failures++; $display("FAIL impulse_mix[%0d] got=%0d exp=%0d", k, got_mix[k], em); end
        end
    endtask

    task automatic test_feedback();
        int ea;
        do_reset();
        for (int i = 0; i < 18; i++) set_sample(i, (i == 0) ? 228 : 128, 4, 0, 1, 0);
        run_samples(18, 0);
        for (int k = 0; k < 18; k++) begin
            ea = (k == 4) ? 228 : (k == 8) ? 178 : (k == 12) ? 153 : (k == 16) ? 140 : 128;
            checks++;
            if (got_a[k] !== ea) begin failures++; $display("FAIL feedback_tap_a[%0d] got=%0d exp=%0d", k, got_a[k], ea); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) set_sample(i, 255, 1, 2, 0, 0);
        run_samples(3, 0);
        checks++;
        if (got_mix[2] !== 255) begin failures++; $display("FAIL sat_high_mix got=%0d exp=255", got_mix[2]); end
        do_reset();
        for (int i = 0; i < 3; i++) set_sample(i, 0, 1, 2, 0, 0);
        run_samples(3, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_mix[k] !== 0) begin failures++; $display("FAIL sat_low_mix[%0d] got=%0d exp=0", k, got_mix[k]); end
        end
    endtask

    task automatic test_fill_gating();
        int ea;
        do_reset();
        for (int i = 0; i < 512; i++) set_sample(i, 200, 0, 0, 0, 0);
        run_samples(512, 0);
        do_reset();
        for (int i = 0; i < 30; i++) set_sample(i, i, 10, 0, 0, 0);
        run_samples(30, 0);
        for (int k = 0; k < 30; k++) begin
            ea = (k < 10) ? 128 : (k - 10);
            checks++;
            if (got_a[k] !== ea) begin failures++; $display("FAIL fill_tap_a[%0d] got=%0d exp=%0d", k, got_a[k], ea); end
        end
    endtask

    task automatic test_wrap();
        int ea;
        do_reset();
        for (int i = 0; i < 600; i++) set_sample(i, i % 256, 511, $urandom_range(0, 511), 0, 0);
        run_samples(600, 0);
        for (int k = 0; k < 600; k++) begin
            ea = (k < 511) ? 128 : ((k - 511) % 256);
            checks += 2;
            if (got_a[k] !== ea) begin failures++; $display("FAIL wrap_tap_a[%0d] got=%0d exp=%0d", k, got_a[k], ea); end
            if (got_b[k] !== ex_b[k]) begin failures++; $display("FAIL wrap_tap_b[%0d] got=%0d exp=%0d", k, got_b[k], ex_b[k]); end
        end
    endtask

    task automatic test_forwarding_bypass();
        int ea;
        do_reset();
        for (int i = 0; i < 50; i++) set_sample(i, $urandom_range(0, 255), 1, 0, 0, 0);
        run_samples(50, 0);
        for (int k = 0; k < 50; k++) begin
            ea = (k == 0) ? 128 : st_x[k-1];
            checks += 3;
            if (got_a[k] !== ea) begin failures++; $display("FAIL fwd_tap_a[%0d] got=%0d exp=%0d", k, got_a[k], ea); end
            if (got_b[k] !== st_x[k]) begin failures++; $display("FAIL bypass_tap_b[%0d] got=%0d exp=%0d", k, got_b[k], st_x[k]); end
            if (got_orig[k] !== st_x[k]) begin failures++; $display("FAIL fwd_orig[%0d] got=%0d exp=%0d", k, got_orig[k], st_x[k]); end
        end
    endtask

    task automatic test_back_to_back_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_sample(i, $urandom_range(0, 255),
                       ($urandom_range(1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 511),
                       ($urandom_range(1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 511),
                       $urandom_range(0, 1), $urandom_range(0, 3));
        end
        run_samples(400, 30);
        for (int k = 0; k < 400; k++) begin
            checks += 4;
            if (got_orig[k] !== ex_orig[k]) begin failures++; $display("FAIL rand_orig[%0d] got=%0d exp=%0d", k, got_orig[k], ex_orig[k]); end
            if (got_a[k]   !== ex_a[k])   begin failures++; $display("FAIL rand_tap_a[%0d] got=%0d exp=%0d", k, got_a[k], ex_a[k]); end
            if (got_b[k]   !== ex_b[k])   begin failures++; $display("FAIL rand_tap_b[%0d] got=%0d exp=%0d", k, got_b[k], ex_b[k]); end
            if (got_mix[k] !== ex_mix[k]) begin failures++; $display("FAIL rand_mix[%0d] got=%0d exp=%0d", k, got_mix[k], ex_mix[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int x0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en      = 1'b1;
            mic_in  = DW'($urandom_range(0, 255));
            delay_a = AW'(2);
            delay_b = AW'(1);
            fb_en   = 1'b1;
            @(posedge clk);
        end
        #1;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%0b exp=1", out_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks += 5;
        if (original  !== 8'd128) begin failures++; $display("FAIL midrst_original got=%0d exp=128", original); end
        if (tap_a_out !== 8'd128) begin failures++; $display("FAIL midrst_tap_a got=%0d exp=128", tap_a_out); end
        if (tap_b_out !== 8'd128) begin failures++; $display("FAIL midrst_tap_b got=%0d exp=128", tap_b_out); end
        if (mix_out   !== 8'd128) begin failures++; $display("FAIL midrst_mix got=%0d exp=128", mix_out); end
        if (out_valid !== 1'b0)   begin failures++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        x0 = $urandom_range(0, 255);
        set_sample(0, x0, 2, 0, 0, 0);
        run_samples(1, 0);
        checks += 2;
        if (got_a[0] !== 128)  begin failures++; $display("FAIL midrst_after_tap_a got=%0d exp=128", got_a[0]); end
        if (got_orig[0] !== x0) begin failures++; $display("FAIL midrst_after_orig got=%0d exp=%0d", got_orig[0], x0); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_feedback();
        test_saturation();
        test_fill_gating();
        test_wrap();
        test_forwarding_bypass();
        test_back_to_back_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
